rv_alu_pipe: RTL and testbench

- Three-stage registered RV32I execute pipeline: operand select (E1), arithmetic/compare (E2), result select, branch resolve and store formatting (E3).
- Sits between the decode/register-read stage and the memory/write-back stage of the core.
- Output drives the data-bus address/data, the fetch redirect (pc_target/pc_select) and write-back control.

---
 rtl/rv_alu_pkg.sv | 84 ++++++++
 rtl/rv_store_align.sv | 33 +++
 rtl/rv_alu_pipe.sv | 214 +++++++++++++++++++++
 tb/tb_rv_alu_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_alu_pkg.sv
// Shared types and constants for the rv_alu_pipe execute pipeline.
// Holds ALU op codes, operand selects, branch/store encodings, stage structs.
package rv_alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    localparam logic [1:0] OP1_RS1 = 2'd0;
    localparam logic [1:0] OP1_PC  = 2'd1;
    localparam logic       OP2_RS2 = 1'b0;
    localparam logic       OP2_IMM = 1'b1;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;

    typedef struct packed {
        logic        valid;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] addr;
        logic [31:0] link;
        logic [31:0] br_tgt;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        alu_op_e     alu_op;
        logic        reg_write;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        load;
        logic        store;
`ifdef RV_ALU_EXT_C_EN
        logic        compressed;
`endif
    } e1_e2_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic        eq;
        logic        lt;
        logic        ltu;
        logic [31:0] addr;
        logic [31:0] link;
        logic [31:0] br_tgt;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        reg_write;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        load;
        logic        store;
`ifdef RV_ALU_EXT_C_EN
        logic        compressed;
`endif
    } e2_e3_t;

endpackage

// File: rtl/rv_store_align.sv
// Store data lane replication and byte-enable generation.
// Ports: funct3 (width), addr (low bits), rs2 (data) -> wdata, wsel.
module rv_store_align
    import rv_alu_pkg::*;
(
    input  logic [1:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] rs2,
    output logic [31:0] wdata,
    output logic [3:0]  wsel
);

    always_comb begin
        wdata = rs2;
        wsel  = 4'b1111;
        case (funct3)
            ST_SB: begin
                wdata = {4{rs2[7:0]}};
                wsel  = 4'b0001 << addr;
            end
            ST_SH: begin
                // Halfword lane follows addr[1]; addr[0] is dropped.
                wdata = {2{rs2[15:0]}};
                wsel  = 4'b0011 << {addr[1], 1'b0};
            end
            default: begin
                wdata = rs2;
                wsel  = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/rv_alu_pipe.sv
// Three-stage RV32I execute pipeline: E1 operand select, E2 ALU/compare,
// E3 result select, branch resolve, store formatting (registered outputs).
// Inputs: i_clk, i_reset_n (sync, active-low), i_valid, i_pc, i_imm,
//   i_rs1_data, i_rs2_data, i_rd, i_funct3, i_alu_op, i_op1_sel, i_op2_sel,
//   class flags (i_reg_write, i_branch, i_jal, i_jalr, i_load, i_store).
// Outputs: o_valid, o_alu_result, o_add, o_pc_target, o_pc_select, o_load,
//   o_store, o_reg_write, o_wdata, o_wsel, o_rd, o_funct3, o_pc.
// Macro RV_ALU_EXT_C_EN adds i_compressed/o_compressed (pc+2 link).
module rv_alu_pipe
    import rv_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_valid,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [4:0]      i_rd,
    input  logic [2:0]      i_funct3,
    input  logic [3:0]      i_alu_op,
    input  logic [1:0]      i_op1_sel,
    input  logic            i_op2_sel,
    input  logic            i_reg_write,
    input  logic            i_branch,
    input  logic            i_jal,
    input  logic            i_jalr,
    input  logic            i_load,
    input  logic            i_store,
`ifdef RV_ALU_EXT_C_EN
    input  logic            i_compressed,
    output logic            o_compressed,
`endif
    output logic            o_valid,
    output logic [XLEN-1:0] o_alu_result,
    output logic [XLEN-1:0] o_add,
    output logic [XLEN-1:0] o_pc_target,
    output logic            o_pc_select,
    output logic            o_load,
    output logic            o_store,
    output logic            o_reg_write,
    output logic [XLEN-1:0] o_wdata,
    output logic [3:0]      o_wsel,
    output logic [4:0]      o_rd,
    output logic [2:0]      o_funct3,
    output logic [XLEN-1:0] o_pc
);

    e1_e2_t e1_d, e1_q;
    e2_e3_t e2_d, e2_q;

    // E1: operand select and address arithmetic.
    always_comb begin
        e1_d        = '0;
        e1_d.valid  = i_valid;
        case (i_op1_sel)
            OP1_RS1: e1_d.op1 = i_rs1_data;
            OP1_PC:  e1_d.op1 = i_pc;
            default: e1_d.op1 = '0;
        endcase
        e1_d.op2    = (i_op2_sel == OP2_IMM) ? i_imm : i_rs2_data;
        e1_d.rs1    = i_rs1_data;
        e1_d.rs2    = i_rs2_data;
        e1_d.addr   = i_rs1_data + i_imm;
`ifdef RV_ALU_EXT_C_EN
        e1_d.link   = i_pc + (i_compressed ? 32'd2 : 32'd4);
        e1_d.compressed = i_compressed;
`else
        e1_d.link   = i_pc + 32'd4;
`endif
        e1_d.br_tgt = i_pc + i_imm;
        e1_d.pc     = i_pc;
        e1_d.rd     = i_rd;
        e1_d.funct3 = i_funct3;
        e1_d.alu_op = alu_op_e'(i_alu_op);
        // Bubbles must never carry side-effecting control.
        e1_d.reg_write = i_valid & i_reg_write;
        e1_d.branch    = i_valid & i_branch;
        e1_d.jal       = i_valid & i_jal;
        e1_d.jalr      = i_valid & i_jalr;
        e1_d.load      = i_valid & i_load;
        e1_d.store     = i_valid & i_store;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) e1_q <= '0;
        else            e1_q <= e1_d;
    end

    // E2: ALU and branch compares.
    logic [4:0] shamt;
    assign shamt = e1_q.op2[4:0];

    always_comb begin
        e2_d       = '0;
        e2_d.valid = e1_q.valid;
        case (e1_q.alu_op)
            ALU_SUB:  e2_d.result = e1_q.op1 - e1_q.op2;
            ALU_SLL:  e2_d.result = e1_q.op1 << shamt;
            ALU_SLT:  e2_d.result = {31'd0,
                          $signed(e1_q.op1) < $signed(e1_q.op2)};
            ALU_SLTU: e2_d.result = {31'd0, e1_q.op1 < e1_q.op2};
            ALU_XOR:  e2_d.result = e1_q.op1 ^ e1_q.op2;
            ALU_SRL:  e2_d.result = e1_q.op1 >> shamt;
            ALU_SRA:  e2_d.result = $unsigned(
                          $signed(e1_q.op1) >>> shamt);
            ALU_OR:   e2_d.result = e1_q.op1 | e1_q.op2;
            ALU_AND:  e2_d.result = e1_q.op1 & e1_q.op2;
            default:  e2_d.result = e1_q.op1 + e1_q.op2;
        endcase
        e2_d.eq     = (e1_q.rs1 == e1_q.rs2);
        e2_d.lt     = $signed(e1_q.rs1) < $signed(e1_q.rs2);
        e2_d.ltu    = e1_q.rs1 < e1_q.rs2;
        e2_d.addr   = e1_q.addr;
        e2_d.link   = e1_q.link;
        e2_d.br_tgt = e1_q.br_tgt;
        e2_d.rs2    = e1_q.rs2;
        e2_d.pc     = e1_q.pc;
        e2_d.rd     = e1_q.rd;
        e2_d.funct3 = e1_q.funct3;
        e2_d.reg_write = e1_q.reg_write;
        e2_d.branch    = e1_q.branch;
        e2_d.jal       = e1_q.jal;
        e2_d.jalr      = e1_q.jalr;
        e2_d.load      = e1_q.load;
        e2_d.store     = e1_q.store;
`ifdef RV_ALU_EXT_C_EN
        e2_d.compressed = e1_q.compressed;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) e2_q <= '0;
        else            e2_q <= e2_d;
    end

    // E3: result select, branch resolve, store formatting.
    logic        jump;
    logic        taken;
    logic [31:0] res;
    logic [31:0] tgt;
    logic [31:0] sa_wdata;
    logic [3:0]  sa_wsel;

    rv_store_align u_store_align (
        .funct3 (e2_q.funct3[1:0]),
        .addr   (e2_q.addr[1:0]),
        .rs2    (e2_q.rs2),
        .wdata  (sa_wdata),
        .wsel   (sa_wsel)
    );

    always_comb begin
        jump  = e2_q.jal | e2_q.jalr;
        taken = 1'b0;
        case (e2_q.funct3)
            F3_BEQ:  taken = e2_q.eq;
            F3_BNE:  taken = ~e2_q.eq;
            F3_BLT:  taken = e2_q.lt;
            F3_BGE:  taken = ~e2_q.lt;
            F3_BLTU: taken = e2_q.ltu;
            F3_BGEU: taken = ~e2_q.ltu;
            default: taken = 1'b0;
        endcase
        res = e2_q.result;
        unique case (1'b1)
            jump:    res = e2_q.link;
            default: res = e2_q.result;
        endcase
        tgt = e2_q.jalr ? {e2_q.addr[31:1], 1'b0} : e2_q.br_tgt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_valid      <= 1'b0;
            o_alu_result <= '0;
            o_add        <= '0;
            o_pc_target  <= '0;
            o_pc_select  <= 1'b0;
            o_load       <= 1'b0;
            o_store      <= 1'b0;
            o_reg_write  <= 1'b0;
            o_wdata      <= '0;
            o_wsel       <= 4'b0000;
            o_rd         <= '0;
            o_funct3     <= '0;
            o_pc         <= '0;
`ifdef RV_ALU_EXT_C_EN
            o_compressed <= 1'b0;
`endif
        end else begin
            o_valid      <= e2_q.valid;
            o_alu_result <= res;
            o_add        <= e2_q.addr;
            o_pc_target  <= tgt;
            o_pc_select  <= e2_q.valid &
                            (jump | (e2_q.branch & taken));
            o_load       <= e2_q.load;
            o_store      <= e2_q.store;
            o_reg_write  <= e2_q.reg_write;
            o_wdata      <= sa_wdata;
            o_wsel       <= e2_q.store ? sa_wsel : 4'b0000;
            o_rd         <= e2_q.rd;
            o_funct3     <= e2_q.funct3;
            o_pc         <= e2_q.pc;
`ifdef RV_ALU_EXT_C_EN
            o_compressed <= e2_q.compressed;
`endif
        end
    end

endmodule

// File: tb/tb_rv_alu_pipe.sv
// Directed self-checking bench for rv_alu_pipe.
// Covers reset, ALU ops, branches, jumps, stores, flush, back-to-back.
module tb_rv_alu_pipe;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_valid;
    logic [31:0] i_pc, i_imm, i_rs1_data, i_rs2_data;
    logic [4:0]  i_rd;
    logic [2:0]  i_funct3;
    logic [3:0]  i_alu_op;
    logic [1:0]  i_op1_sel;
    logic        i_op2_sel;
    logic        i_reg_write, i_branch, i_jal, i_jalr, i_load, i_store;
`ifdef RV_ALU_EXT_C_EN
    logic        i_compressed;
    logic        o_compressed;
`endif
    logic        o_valid;
    logic [31:0] o_alu_result, o_add, o_pc_target;
    logic        o_pc_select, o_load, o_store, o_reg_write;
    logic [31:0] o_wdata;
    logic [3:0]  o_wsel;
    logic [4:0]  o_rd;
    logic [2:0]  o_funct3;
    logic [31:0] o_pc;

    int n_vec = 0;
    int n_bad = 0;

    rv_alu_pipe #(.XLEN(32)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_valid      (i_valid),
        .i_pc         (i_pc),
        .i_imm        (i_imm),
        .i_rs1_data   (i_rs1_data),
        .i_rs2_data   (i_rs2_data),
        .i_rd         (i_rd),
        .i_funct3     (i_funct3),
        .i_alu_op     (i_alu_op),
        .i_op1_sel    (i_op1_sel),
        .i_op2_sel    (i_op2_sel),
        .i_reg_write  (i_reg_write),
        .i_branch     (i_branch),
        .i_jal        (i_jal),
        .i_jalr       (i_jalr),
        .i_load       (i_load),
        .i_store      (i_store),
`ifdef RV_ALU_EXT_C_EN
        .i_compressed (i_compressed),
        .o_compressed (o_compressed),
`endif
        .o_valid      (o_valid),
        .o_alu_result (o_alu_result),
        .o_add        (o_add),
        .o_pc_target  (o_pc_target),
        .o_pc_select  (o_pc_select),
        .o_load       (o_load),
        .o_store      (o_store),
        .o_reg_write  (o_reg_write),
        .o_wdata      (o_wdata),
        .o_wsel       (o_wsel),
        .o_rd         (o_rd),
        .o_funct3     (o_funct3),
        .o_pc         (o_pc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        i_valid = 0; i_pc = 0; i_imm = 0;
        i_rs1_data = 0; i_rs2_data = 0; i_rd = 0;
        i_funct3 = 0; i_alu_op = 0; i_op1_sel = 0; i_op2_sel = 0;
        i_reg_write = 0; i_branch = 0; i_jal = 0; i_jalr = 0;
        i_load = 0; i_store = 0;
`ifdef RV_ALU_EXT_C_EN
        i_compressed = 0;
`endif
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Accept the staged instruction, then two bubbles: output visible.
    task automatic run3();
        step();
        clr();
        step();
        step();
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        clr();
        i_valid = 1; i_reg_write = 1; i_alu_op = op;
        i_rs1_data = a; i_rs2_data = b; i_rd = 5'd7;
    endtask

    task automatic set_br(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b);
        clr();
        i_valid = 1; i_branch = 1; i_funct3 = f3; i_alu_op = 4'd1;
        i_rs1_data = a; i_rs2_data = b; i_pc = 32'h100; i_imm = 32'h20;
    endtask

    task automatic set_st(input logic [2:0] f3, input logic [31:0] imm);
        clr();
        i_valid = 1; i_store = 1; i_funct3 = f3; i_op2_sel = 1;
        i_rs1_data = 32'h100; i_imm = imm; i_rs2_data = 32'h1234_56AB;
    endtask

    task automatic apply_slot(input int k);
        clr();
        case (k)
            0: begin
                i_valid = 1; i_reg_write = 1; i_alu_op = 4'd0;
                i_rs1_data = 3; i_rs2_data = 4; i_rd = 1;
            end
            2: begin
                i_valid = 1; i_reg_write = 1; i_alu_op = 4'd5;
                i_rs1_data = 32'hF0F0; i_rs2_data = 32'hFF00; i_rd = 2;
            end
            3: begin
                i_valid = 1; i_reg_write = 1; i_alu_op = 4'd2;
                i_rs1_data = 1; i_op2_sel = 1; i_imm = 31; i_rd = 3;
            end
            5: begin
                i_valid = 1; i_reg_write = 1; i_jal = 1;
                i_pc = 32'h200; i_imm = 32'h10; i_rd = 4;
            end
            default: begin
                // Bubble with stale control flags that must be ignored.
                i_reg_write = 1; i_store = 1; i_jal = 1;
                i_load = 1; i_branch = 1;
            end
        endcase
    endtask

    function automatic logic [31:0] exp_res(input int k);
        case (k)
            0: return 32'd7;
            2: return 32'h0FF0;
            3: return 32'h8000_0000;
            5: return 32'h204;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [4:0] exp_rd(input int k);
        case (k)
            0: return 5'd1;
            2: return 5'd2;
            3: return 5'd3;
            5: return 5'd4;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic exp_vld(input int k);
        return (k == 0) || (k == 2) || (k == 3) || (k == 5);
    endfunction

    initial begin
        // Reset held two cycles with a live jump/store at the input.
        clr();
        i_reset_n = 0;
        i_valid = 1; i_jal = 1; i_reg_write = 1; i_store = 1;
        i_pc = 32'h40; i_rs1_data = 32'hDEAD_BEEF;
        step();
        step();
        chk("rst_valid", o_valid, 0);
        chk("rst_regw", o_reg_write, 0);
        chk("rst_psel", o_pc_select, 0);
        chk("rst_store", o_store, 0);
        chk("rst_res", o_alu_result, 0);
        chk("rst_wsel", o_wsel, 0);

        // First instruction after reset: exactly 3 cycles.
        i_reset_n = 1;
        set_alu(4'd0, 32'hFFFF_FFFF, 32'd1);
        i_rd = 5'd5;
        step();
        clr();
        chk("lat_c1", o_valid, 0);
        step();
        chk("lat_c2", o_valid, 0);
        step();
        chk("lat_c3", o_valid, 1);
        chk("add_wrap", o_alu_result, 32'h0);
        chk("add_rd", o_rd, 5);
        chk("add_regw", o_reg_write, 1);

        set_alu(4'd1, 32'd5, 32'd7);
        run3();
        chk("sub", o_alu_result, 32'hFFFF_FFFE);

        set_alu(4'd7, 32'h8000_0000, 32'd0);
        i_op2_sel = 1; i_imm = 32'd4;
        run3();
        chk("sra", o_alu_result, 32'hF800_0000);

        set_alu(4'd3, 32'hFFFF_FFFF, 32'd1);
        run3();
        chk("slt", o_alu_result, 32'd1);

        set_alu(4'd4, 32'hFFFF_FFFF, 32'd1);
        run3();
        chk("sltu", o_alu_result, 32'd0);

        set_alu(4'd12, 32'd10, 32'd20);
        run3();
        chk("op12_add", o_alu_result, 32'd30);

        set_alu(4'd0, 32'd0, 32'd0);
        i_op1_sel = 1; i_pc = 32'h1000; i_op2_sel = 1; i_imm = 32'h5000;
        run3();
        chk("auipc", o_alu_result, 32'h6000);
        chk("pc_pass", o_pc, 32'h1000);

        set_alu(4'd0, 32'h55, 32'd0);
        i_op1_sel = 2; i_op2_sel = 1; i_imm = 32'hABCD_E000;
        run3();
        chk("lui", o_alu_result, 32'hABCD_E000);

        set_br(3'b100, 32'hFFFF_FFFE, 32'd3);
        run3();
        chk("blt_sel", o_pc_select, 1);
        chk("blt_tgt", o_pc_target, 32'h120);
        chk("blt_regw", o_reg_write, 0);

        set_br(3'b111, 32'hFFFF_FFFE, 32'd3);
        run3();
        chk("bgeu_sel", o_pc_select, 1);

        set_br(3'b110, 32'hFFFF_FFFE, 32'd3);
        run3();
        chk("bltu_sel", o_pc_select, 0);
        chk("bltu_tgt", o_pc_target, 32'h120);

        set_br(3'b000, 32'd7, 32'd7);
        run3();
        chk("beq_sel", o_pc_select, 1);

        set_br(3'b001, 32'd7, 32'd7);
        run3();
        chk("bne_sel", o_pc_select, 0);

        set_br(3'b010, 32'd7, 32'd7);
        run3();
        chk("f3_010", o_pc_select, 0);

        clr();
        i_valid = 1; i_jalr = 1; i_reg_write = 1; i_op2_sel = 1;
        i_rs1_data = 32'h1003; i_imm = 0; i_pc = 32'h40; i_rd = 1;
        run3();
        chk("jalr_tgt", o_pc_target, 32'h1002);
        chk("jalr_link", o_alu_result, 32'h44);
        chk("jalr_sel", o_pc_select, 1);

        clr();
        i_valid = 1; i_jal = 1; i_reg_write = 1;
        i_pc = 32'h40; i_imm = 32'hFFFF_FFF8;
        run3();
        chk("jal_tgt", o_pc_target, 32'h38);
        chk("jal_link", o_alu_result, 32'h44);
        chk("jal_sel", o_pc_select, 1);

        set_st(3'b000, 32'd3);
        run3();
        chk("sb_addr", o_add, 32'h103);
        chk("sb_wdata", o_wdata, 32'hABAB_ABAB);
        chk("sb_wsel", o_wsel, 4'b1000);
        chk("sb_store", o_store, 1);
        chk("sb_regw", o_reg_write, 0);

        set_st(3'b001, 32'd2);
        run3();
        chk("sh_wdata", o_wdata, 32'h56AB_56AB);
        chk("sh_wsel", o_wsel, 4'b1100);

        set_st(3'b010, 32'd0);
        run3();
        chk("sw_wdata", o_wdata, 32'h1234_56AB);
        chk("sw_wsel", o_wsel, 4'b1111);

        clr();
        i_valid = 1; i_load = 1; i_reg_write = 1; i_funct3 = 3'b010;
        i_rs1_data = 32'hFFFF_FFFF; i_imm = 32'd1; i_op2_sel = 1;
        run3();
        chk("ld_addr", o_add, 32'h0);
        chk("ld_load", o_load, 1);
        chk("ld_wsel", o_wsel, 0);
        chk("ld_f3", o_funct3, 3'b010);

        // Mid-flight reset flushes queued instructions.
        clr();
        i_valid = 1; i_jal = 1; i_reg_write = 1; i_pc = 32'h80;
        step();
        set_alu(4'd0, 32'd1, 32'd1);
        step();
        i_reset_n = 0;
        clr();
        step();
        chk("fl_valid", o_valid, 0);
        chk("fl_psel", o_pc_select, 0);
        i_reset_n = 1;
        step();
        step();
        chk("fl_drain", o_valid, 0);
        chk("fl_regw", o_reg_write, 0);

        // Back-to-back with bubbles.
        for (int t = 0; t < 8; t++) begin
            if (t < 6) apply_slot(t);
            else       clr();
            step();
            if (t >= 2) begin
                chk($sformatf("b2b_vld%0d", t - 2), o_valid,
                    exp_vld(t - 2));
                chk($sformatf("b2b_regw%0d", t - 2), o_reg_write,
                    exp_vld(t - 2));
                chk($sformatf("b2b_psel%0d", t - 2), o_pc_select,
                    (t - 2) == 5);
                chk($sformatf("b2b_st%0d", t - 2), o_store, 0);
                chk($sformatf("b2b_wsel%0d", t - 2), o_wsel, 0);
                if (exp_vld(t - 2)) begin
                    chk($sformatf("b2b_res%0d", t - 2), o_alu_result,
                        exp_res(t - 2));
                    chk($sformatf("b2b_rd%0d", t - 2), o_rd,
                        exp_rd(t - 2));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
